skip_add_sequencer: RTL and testbench

Multi-cycle carry-skip adder controller. It accepts one WIDTH-bit add request through a valid/ready handshake. It then sequences one BLOCK-bit slice per cycle, LSB slice first, forwarding the carry between slices with the skip rule. It returns the sum, the carry-out and a count of skipped slices. It sits in the benchmarking datapath as an area-lean alternative to the fully combinational carry-skip chain.

---
 rtl/skip_add_sequencer_pkg.sv | 19 +
 rtl/skip_add_sequencer_if.sv | 36 +++
 rtl/skip_add_sequencer_slice.sv | 33 +++
 rtl/skip_add_sequencer.sv | 119 +++++++++++
 tb/tb_skip_add_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skip_add_sequencer_pkg.sv
// skip_add_pkg
// Shared definitions for the multi-cycle carry-skip adder sequencer:
//   state_t                - FSM state encoding (IDLE, RUN, DONE)
//   skip_count_width(n)    - bits needed to count up to n skipped slices
package skip_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold the value n itself (every slice skipped),
    // so it needs enough bits for n+1 distinct values.
    function automatic int skip_count_width(input int num_blocks);
        return $clog2(num_blocks + 1);
    endfunction

endpackage

// File: rtl/skip_add_sequencer_if.sv
// skip_add_if
// Request/response bundle between a requester and skip_add_sequencer.
//   in_valid/in_ready   - request handshake; a, b, cin travel with the request
//   out_valid/out_ready - result handshake; sum, cout, skip_count travel with it
// Modports: master = requester/consumer side, slave = adder side.
interface skip_add_if #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
);
    import skip_add_pkg::*;

    localparam int NUM_BLOCKS = WIDTH / BLOCK;
    localparam int SKIP_W     = skip_count_width(NUM_BLOCKS);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic [SKIP_W-1:0] skip_count;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, skip_count
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, skip_count
    );

endinterface

// File: rtl/skip_add_sequencer_slice.sv
// skip_slice
// Purely combinational BLOCK-bit carry-skip slice.
//   a, b      - operand slices
//   carry_in  - carry entering the slice
//   sum       - slice sum bits
//   carry_out - carry leaving the slice (skip term OR ripple carry)
//   skip      - high when the carry was produced by the skip term
module skip_slice #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             carry_in,
    output logic [BLOCK-1:0] sum,
    output logic             carry_out,
    output logic             skip
);

    logic [BLOCK:0] ripple;
    logic           p_all;

    // The ripple result is kept at BLOCK+1 bits so the slice carry is never lost.
    // When every bit position propagates, an incoming carry passes straight
    // through the slice; that is the skip term.
    always_comb begin
        ripple    = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, carry_in};
        p_all     = &(a | b);
        skip      = p_all & carry_in;
        sum       = ripple[BLOCK-1:0];
        carry_out = skip | ripple[BLOCK];
    end

endmodule

// File: rtl/skip_add_sequencer.sv
// skip_add_sequencer
// Multi-cycle carry-skip adder: accepts one WIDTH-bit add, then processes one
// BLOCK-bit slice per cycle (LSB slice first) through a single skip_slice.
//   clk, rst - clock and synchronous active-high reset
//   bus      - skip_add_if slave: request (a, b, cin) and result
//              (sum, cout, skip_count) with valid/ready handshakes
module skip_add_sequencer
    import skip_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic       clk,
    input logic       rst,
    skip_add_if.slave bus
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK;
    localparam int SKIP_W     = skip_count_width(NUM_BLOCKS);
    localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    // Reject geometries the slice sequencing cannot cover exactly.
    generate
        if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
            $error("skip_add_sequencer: WIDTH must be a multiple of BLOCK and BLOCK >= 1");
        end
    endgenerate

    state_t                            state;
    logic [NUM_BLOCKS-1:0][BLOCK-1:0]  a_blk;
    logic [NUM_BLOCKS-1:0][BLOCK-1:0]  b_blk;
    logic [NUM_BLOCKS-1:0][BLOCK-1:0]  sum_blk;
    logic                              carry;
    logic [IDX_W-1:0]                  idx;
    logic [SKIP_W-1:0]                 skip_cnt;
    logic                              cout_r;
    logic                              in_ready_r;
    logic                              out_valid_r;

    logic [BLOCK-1:0]                  slice_sum;
    logic                              slice_carry;
    logic                              slice_skip;

    // Operands are stored as arrays of slices so the current slice is a plain
    // array index rather than a computed bit offset.
    skip_slice #(.BLOCK(BLOCK)) u_slice (
        .a         (a_blk[idx]),
        .b         (b_blk[idx]),
        .carry_in  (carry),
        .sum       (slice_sum),
        .carry_out (slice_carry),
        .skip      (slice_skip)
    );

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.sum        = sum_blk;
    assign bus.cout       = cout_r;
    assign bus.skip_count = skip_cnt;

    // Single FSM with registered handshake and result outputs. Accepting a
    // request zeroes the previous result so stale upper slices never leak;
    // the last RUN slice raises out_valid directly so DONE starts valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_blk       <= '0;
            b_blk       <= '0;
            sum_blk     <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            skip_cnt    <= '0;
            cout_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_blk      <= bus.a;
                        b_blk      <= bus.b;
                        carry      <= bus.cin;
                        idx        <= '0;
                        skip_cnt   <= '0;
                        sum_blk    <= '0;
                        cout_r     <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_blk[idx] <= slice_sum;
                    carry        <= slice_carry;
                    skip_cnt     <= skip_cnt + SKIP_W'(slice_skip);
                    if (idx == IDX_W'(NUM_BLOCKS - 1)) begin
                        cout_r      <= slice_carry;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skip_add_sequencer.sv
// tb_skip_add_sequencer
// Self-checking bench for skip_add_sequencer (WIDTH=16, BLOCK=4). Expected
// results come from an arithmetic reference model of the carry-skip rules.
module tb_skip_add_sequencer;

    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int NB     = WIDTH / BLOCK;
    localparam int SKIP_W = 3;
    localparam int LAT    = NB + 1;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Edge counter used to timestamp handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    skip_add_if #(.WIDTH(WIDTH), .BLOCK(BLOCK)) bus ();

    skip_add_sequencer #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: full sum by plain addition; the carry entering slice i is the
    // carry out of the low i*BLOCK bits of a+b+cin. A slice skips when all its
    // bits propagate and that incoming carry is 1.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, output logic [WIDTH-1:0] s,
                         output logic c, output logic [SKIP_W-1:0] k);
        longint unsigned av, bv, total, mask, part, orsl, full;
        int n;
        av    = longint'(a);
        bv    = longint'(b);
        total = av + bv + longint'(cin);
        s     = total[WIDTH-1:0];
        c     = total[WIDTH];
        full  = (64'd1 << BLOCK) - 1;
        n     = 0;
        for (int i = 0; i < NB; i++) begin
            mask = (64'd1 << (i * BLOCK)) - 1;
            part = (av & mask) + (bv & mask) + longint'(cin);
            orsl = ((av | bv) >> (i * BLOCK)) & full;
            if (orsl == full && (part >> (i * BLOCK)) != 0) n++;
        end
        k = SKIP_W'(n);
    endtask

    // Drives one request, waits for the result, holds out_ready low for
    // 'hold' cycles, captures the outputs and completes the handshake.
    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic icin, input int hold,
                         output logic [WIDTH-1:0] s, output logic c,
                         output logic [SKIP_W-1:0] k, output int lat,
                         output bit timeout);
        int waitc;
        timeout = 1'b0;
        @(negedge clk);
        bus.a = ia; bus.b = ib; bus.cin = icin;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) timeout = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) timeout = 1'b1;
        repeat (hold) @(negedge clk);
        s = bus.sum; c = bus.cout; k = bus.skip_count;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.cout} !== 3'b100 ||
            bus.sum !== 16'h0000 || bus.skip_count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b skip=%0d want rdy=1 vld=0 sum=0000 cout=0 skip=0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.skip_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0]  va [3] = '{16'h1234, 16'hFFFF, 16'h0000};
        logic [WIDTH-1:0]  vb [3] = '{16'h4321, 16'h0001, 16'h0000};
        logic              vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0]  es [3] = '{16'h5555, 16'h0000, 16'h0001};
        logic              ec [3] = '{1'b0, 1'b1, 1'b0};
        logic [SKIP_W-1:0] ek [3] = '{3'd0, 3'd3, 3'd0};
        logic [WIDTH-1:0]  s;
        logic              c;
        logic [SKIP_W-1:0] k;
        int                lat;
        bit                to;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], 0, s, c, k, lat, to);
            tests++;
            if (to !== 1'b0 || lat !== LAT) begin
                fails++;
                $display("[TB] FAIL directed%0d_latency: got %0d timeout=%b want %0d", i, lat, to, LAT);
            end
            tests++;
            if (s !== es[i] || c !== ec[i] || k !== ek[i]) begin
                fails++;
                $display("[TB] FAIL directed%0d_result: got sum=%h cout=%b skip=%0d want sum=%h cout=%b skip=%0d",
                         i, s, c, k, es[i], ec[i], ek[i]);
            end
            tests++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL directed%0d_return_idle: got rdy=%b vld=%b want rdy=1 vld=0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int waitc;
        @(negedge clk);
        bus.a = 16'hF0F0; bus.b = 16'h0F0F; bus.cin = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        waitc = 0;
        while (bus.out_valid !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        for (int h = 0; h < 3; h++) begin
            // A stray request during the hold must be ignored.
            bus.in_valid = (h == 1);
            bus.a = 16'h7777; bus.b = 16'h1111; bus.cin = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 16'h0000 ||
                bus.cout !== 1'b1 || bus.skip_count !== 3'd4) begin
                fails++;
                $display("[TB] FAIL backpressure_hold%0d: got vld=%b rdy=%b sum=%h cout=%b skip=%0d want vld=1 rdy=0 sum=0000 cout=1 skip=4",
                         h, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.skip_count);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0]  s;
        logic              c;
        logic [SKIP_W-1:0] k;
        int                lat;
        bit                to;
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 ||
            bus.cout !== 1'b0 || bus.skip_count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_run: got rdy=%b vld=%b sum=%h cout=%b skip=%0d want rdy=1 vld=0 sum=0000 cout=0 skip=0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.skip_count);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 0, s, c, k, lat, to);
        tests++;
        if (to !== 1'b0 || s !== 16'h0002 || c !== 1'b0 || k !== 3'd0) begin
            fails++;
            $display("[TB] FAIL after_reset_op: got sum=%h cout=%b skip=%0d timeout=%b want sum=0002 cout=0 skip=0",
                     s, c, k, to);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0]  qa [2];
        logic [WIDTH-1:0]  qb [2];
        logic              qc [2];
        logic [WIDTH-1:0]  rs [2];
        logic              rc [2];
        logic [SKIP_W-1:0] rk [2];
        int                acc_cyc [2];
        int                hs_cyc [2];
        logic [WIDTH-1:0]  es;
        logic              ec;
        logic [SKIP_W-1:0] ek;
        int                next, got;
        bit                adv;
        for (int i = 0; i < 2; i++) begin
            qa[i] = 16'($urandom);
            qb[i] = (i == 0) ? ~qa[i] : 16'($urandom);
            qc[i] = 1'b1;
            acc_cyc[i] = 0; hs_cyc[i] = 0;
        end
        next = 0; got = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.a = qa[0]; bus.b = qb[0]; bus.cin = qc[0]; bus.in_valid = 1'b1;
        for (int t = 0; t < 40 && got < 2; t++) begin
            if (bus.out_valid === 1'b1) begin
                hs_cyc[got] = cyc;
                rs[got] = bus.sum; rc[got] = bus.cout; rk[got] = bus.skip_count;
                got++;
            end
            adv = (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && next < 2);
            if (adv) acc_cyc[next] = cyc;
            @(negedge clk);
            if (adv) begin
                next++;
                if (next < 2) begin
                    bus.a = qa[next]; bus.b = qb[next]; bus.cin = qc[next];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (got !== 2) begin
            fails++;
            $display("[TB] FAIL b2b_timeout: got %0d results want 2", got);
        end else begin
            tests++;
            if (acc_cyc[1] - hs_cyc[0] !== 1) begin
                fails++;
                $display("[TB] FAIL b2b_reaccept_gap: got %0d cycles want 1", acc_cyc[1] - hs_cyc[0]);
            end
            for (int i = 0; i < 2; i++) begin
                model(qa[i], qb[i], qc[i], es, ec, ek);
                tests++;
                if (rs[i] !== es || rc[i] !== ec || rk[i] !== ek) begin
                    fails++;
                    $display("[TB] FAIL b2b_result%0d: got sum=%h cout=%b skip=%0d want sum=%h cout=%b skip=%0d",
                             i, rs[i], rc[i], rk[i], es, ec, ek);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0]  ra, rb, s, es;
        logic              rcin, c, ec;
        logic [SKIP_W-1:0] k, ek;
        int                lat;
        bit                to;
        for (int i = 0; i < 30; i++) begin
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 1) == 1) ? ~ra : 16'($urandom);
            rcin = 1'($urandom);
            model(ra, rb, rcin, es, ec, ek);
            do_op(ra, rb, rcin, $urandom_range(0, 2), s, c, k, lat, to);
            tests++;
            if (to !== 1'b0 || lat !== LAT || s !== es || c !== ec || k !== ek) begin
                fails++;
                $display("[TB] FAIL random%0d a=%h b=%h cin=%b: got sum=%h cout=%b skip=%0d lat=%0d want sum=%h cout=%b skip=%0d lat=%0d",
                         i, ra, rb, rcin, s, c, k, lat, es, ec, ek, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
